// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch PC generator.
//   pc_state_e       - fetch FSM states (BOOT, RUN, HALT)
//   PC_RESET_VEC     - default PC loaded at reset
//   PC_INSTR_BYTES   - default sequential increment
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [63:0] PC_RESET_VEC   = 64'h0;
    localparam int unsigned PC_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack as a circular buffer.
//   clk_i, reset_ni : clock, synchronous active-low reset
//   clear_i         : drop all entries (highest priority)
//   pop_i           : remove top entry (ignored when empty)
//   push_i          : add push_data_i on top; when full the oldest entry is overwritten
//   top_o           : current top entry
//   empty_o         : no valid entries
// Pop and push together replace the top entry in place (pop first, then push).
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][XLEN-1:0] mem_q, mem_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [PW-1:0]              ptr_inc;
    logic                       do_pop;

    assign ptr_inc = ptr_q + PW'(1);
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (do_pop && push_i) begin
            mem_d[ptr_q] = push_data_i;
        end else if (do_pop) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push_i) begin
            // Wrapping the pointer lands on the oldest slot once full.
            ptr_d          = ptr_inc;
            mem_d[ptr_inc] = push_data_i;
            if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            mem_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign top_o   = mem_q[ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with optional return-address stack.
//   clk_i, reset_ni          : clock, synchronous active-low reset
//   ready_i                  : fetch accepted pc_o this cycle
//   halt_i                   : level halt request
//   redirect_valid_i/pc_i    : resolved taken branch/jump target
//   trap_i/trap_vec_i        : trap pulse and handler address
//   call_i, ret_i            : pc_o is a call / return
//   pc_o, pc_valid_o         : fetch PC and its valid flag (RUN only)
//   misaligned_o             : pulse alongside a trap/redirect target whose low bits were cleared
// Macro PC_GEN_RAS_EN: include the return-address stack; otherwise call_i/ret_i are ignored.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  RESET_VEC   = XLEN'(PC_RESET_VEC),
    parameter int unsigned      INSTR_BYTES = PC_INSTR_BYTES,
    parameter int unsigned      RAS_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            ready_i,
    input  logic            halt_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misaligned_o
);
    localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK = STEP - XLEN'(1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;

    logic            live;
    logic            take_trap, take_redir, advance;
    logic [XLEN-1:0] tgt_raw;
    logic            ras_hit;
    logic [XLEN-1:0] ras_top;

    // BOOT only exists to present RESET_VEC for one cycle, so control
    // inputs are not acted on until RUN/HALT.
    assign live       = (state_q != BOOT);
    assign take_trap  = live && trap_i;
    assign take_redir = live && redirect_valid_i && !trap_i;
    assign advance    = (state_q == RUN) && ready_i && !trap_i && !redirect_valid_i;
    assign tgt_raw    = trap_i ? trap_vec_i : redirect_pc_i;

`ifdef PC_GEN_RAS_EN
    logic ras_push, ras_pop, ras_empty;

    assign ras_push = advance && call_i;
    assign ras_pop  = advance && ret_i;
    assign ras_hit  = ras_pop && !ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .clear_i     (take_trap),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_q + STEP),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );
`else
    logic unused_ras_ins;
    assign unused_ras_ins = call_i ^ ret_i;
    assign ras_hit        = 1'b0;
    assign ras_top        = '0;
`endif

    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (take_trap || take_redir) begin
            pc_d         = tgt_raw & ~LOW_MASK;
            misaligned_d = |(tgt_raw & LOW_MASK);
        end else if (ras_hit) begin
            pc_d = ras_top;
        end else if (advance) begin
            pc_d = pc_q + STEP;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i && !trap_i) state_d = HALT;
            HALT:    if (!halt_i || trap_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VEC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = (state_q == RUN);
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and random stimulus for pc_gen, checked against a
// queue-based reference model. Model follows PC_GEN_RAS_EN like the DUT.
module tb_pc_gen;
    localparam int unsigned IB    = 4;
    localparam int unsigned DEPTH = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        ready_i = 1'b0, halt_i = 1'b0, redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0, trap_vec_i = '0;
    logic        trap_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
    logic [63:0] pc_o;
    logic        pc_valid_o, misaligned_o;

    pc_gen dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .ready_i          (ready_i),
        .halt_i           (halt_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_i           (trap_i),
        .trap_vec_i       (trap_vec_i),
        .call_i           (call_i),
        .ret_i            (ret_i),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o),
        .misaligned_o     (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [63:0] m_pc;
    int          m_st;
    bit          m_mis;
    logic [63:0] m_ras[$];

    int checks = 0;
    int errors = 0;

    task automatic model_edge(input bit rst, rdy, hlt, rv, input logic [63:0] rpc,
                              input bit t, input logic [63:0] tv, input bit c, rt);
        logic [63:0] tgt;
        int          nst;
        if (!rst) begin
            m_pc = 64'h0; m_st = S_BOOT; m_mis = 1'b0; m_ras.delete();
            return;
        end
        nst = m_st;
        if (m_st == S_BOOT) nst = S_RUN;
        else if (m_st == S_RUN && hlt && !t) nst = S_HALT;
        else if (m_st == S_HALT && (!hlt || t)) nst = S_RUN;
        m_mis = 1'b0;
        if (m_st != S_BOOT && (t || rv)) begin
            tgt   = t ? tv : rpc;
            m_pc  = tgt - (tgt % IB);
            m_mis = (tgt % IB) != 0;
            if (t) m_ras.delete();
        end else if (m_st == S_RUN && rdy) begin
            logic [63:0] ret_addr;
            ret_addr = m_pc + IB;
            if (RAS_EN && rt && m_ras.size() > 0) m_pc = m_ras.pop_back();
            else m_pc = m_pc + IB;
            if (RAS_EN && c) begin
                m_ras.push_back(ret_addr);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
        m_st = nst;
    endtask

    task automatic step(input string tag, input bit rst, rdy, hlt, rv, input logic [63:0] rpc,
                        input bit t, input logic [63:0] tv, input bit c, rt);
        reset_ni = rst; ready_i = rdy; halt_i = hlt; redirect_valid_i = rv;
        redirect_pc_i = rpc; trap_i = t; trap_vec_i = tv; call_i = c; ret_i = rt;
        model_edge(rst, rdy, hlt, rv, rpc, t, tv, c, rt);
        @(posedge clk_i); #1;
        checks++;
        assert (pc_o === m_pc) else begin
            errors++; $error("FAIL %s pc_o got %h exp %h", tag, pc_o, m_pc);
        end
        checks++;
        assert (pc_valid_o === (m_st == S_RUN)) else begin
            errors++; $error("FAIL %s pc_valid_o got %b exp %b", tag, pc_valid_o, (m_st == S_RUN));
        end
        checks++;
        assert (misaligned_o === m_mis) else begin
            errors++; $error("FAIL %s misaligned_o got %b exp %b", tag, misaligned_o, m_mis);
        end
    endtask

    // Shorthands: sequential fetch, redirect, call/ret
    task automatic seq(input string tag, input bit rdy);
        step(tag, 1, rdy, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic redir(input string tag, input bit rdy, input logic [63:0] a);
        step(tag, 1, rdy, 0, 1, a, 0, 0, 0, 0);
    endtask
    task automatic cr(input string tag, input bit c, rt);
        step(tag, 1, 1, 0, 0, 0, 0, 0, c, rt);
    endtask

    initial begin
        logic [63:0] ra, ta;
        m_pc = 0; m_st = S_BOOT; m_mis = 0;

        // Reset and boot sequence
        step("reset0", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 0, 1, 0, 1, 64'h40, 1, 64'h80, 1, 1);
        step("boot", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        seq("seq4", 1);
        seq("seq8", 1);
        seq("seqC", 1);

        // Redirect with ready low, then hold
        redir("to10", 1, 64'h10);
        redir("to200_nordy", 0, 64'h200);
        seq("hold200", 0);
        seq("hold200b", 0);

        // Misaligned redirect and trap
        redir("mis203", 1, 64'h203);
        seq("mis_clear", 1);
        step("trap_mis", 1, 1, 0, 1, 64'h500, 1, 64'h1002, 0, 0);
        seq("after_trap_mis", 1);

        // RAS: calls at 0x100 and 0x300, returns from 0x400
        redir("to100", 1, 64'h100);
        cr("call100", 1, 0);
        redir("to300", 1, 64'h300);
        cr("call300", 1, 0);
        redir("to400", 1, 64'h400);
        cr("ret304", 0, 1);
        cr("ret104", 0, 1);
        cr("ret_empty", 0, 1);
        // Fill past depth, then drain
        for (int i = 0; i < DEPTH + 2; i++) begin
            redir("fill_redir", 1, 64'h1000 * (i + 1));
            cr("fill_call", 1, 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cr("drain_ret", 0, 1);
        // Call and ret together
        redir("to700", 1, 64'h700);
        cr("call_a", 1, 0);
        redir("to900", 1, 64'h900);
        cr("call_ret", 1, 1);
        cr("ret_after_cr", 0, 1);
        cr("ret_after_cr2", 0, 1);
        // Redirect leaves RAS intact; ret/call with ready low do nothing
        cr("call_b", 1, 0);
        step("redir_with_ret", 1, 1, 0, 1, 64'h2000, 0, 0, 1, 1);
        step("ret_nordy", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cr("ret_after_redir", 0, 1);

        // Halt, redirect in HALT, trap out of HALT clears RAS
        cr("call_c", 1, 0);
        step("halt_in", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("halt_hold", 1, 1, 1, 0, 0, 0, 0, 1, 1);
        step("halt_redir", 1, 1, 1, 1, 64'h600, 0, 0, 0, 0);
        step("halt_trap", 1, 1, 1, 0, 0, 1, 64'h80, 0, 0);
        cr("ret_after_trap", 0, 1);
        step("halt_in2", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("unhalt", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        seq("run_again", 1);

        // Wrap at the top of the address space
        redir("to_top", 1, 64'hFFFF_FFFF_FFFF_FFFC);
        seq("wrap0", 1);

        // Reset in the middle of activity
        cr("call_d", 1, 0);
        step("mid_reset", 0, 1, 0, 1, 64'h3000, 1, 64'h4000, 1, 0);
        step("post_boot", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cr("ret_post_reset", 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            ta = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            step("rand", $urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, ra,
                 $urandom_range(0, 11) == 0, ta,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
